// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between the CPU/debug requesters, the arbiter and one single-port RAM.
// The master modport is the requester/RAM side; the slave modport is the arbiter.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_rvalid;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wdata;
  logic                  dbg_gnt;
  logic [DATA_WIDTH-1:0] dbg_rdata;
  logic                  dbg_rvalid;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_cs_n;
  logic                  ram_we_n;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    input  ram_addr, ram_wdata, ram_cs_n, ram_we_n,
    output ram_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    output ram_addr, ram_wdata, ram_cs_n, ram_we_n,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port RAM between a high-priority CPU port and a debug port,
// with a bounded-starvation counter that eventually lets a waiting debug request win.
module ram_port_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  ram_port_arbiter_if.slave bus,
  output logic [1:0]        slot_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } slot_e;

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  slot_e                 slot;
  logic                  rd_flag;
  logic [CW-1:0]         starve_cnt;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_wdata_q;
  logic                  ram_cs_n_q;
  logic                  ram_we_n_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;
  logic                  cpu_rvalid_q;
  logic                  dbg_rvalid_q;
  logic                  dbg_win;
  logic                  cpu_gnt;
  logic                  dbg_gnt;
  logic                  cpu_xfer;
  logic                  dbg_xfer;

  // Handshake: a port transfers on the posedge where req && gnt; the requester keeps
  // req/we/addr/wdata stable until then, and req still high afterwards is a new request.
  always_comb begin
    dbg_win = bus.dbg_req &&
              (!bus.cpu_req || ((STARVE_LIMIT != 0) && (starve_cnt == LIMIT_C)));
    cpu_gnt = n_reset && bus.cpu_req && !dbg_win;
    dbg_gnt = n_reset && dbg_win;
  end

  assign cpu_xfer = bus.cpu_req && cpu_gnt;
  assign dbg_xfer = bus.dbg_req && dbg_gnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      slot         <= IDLE;
      rd_flag      <= 1'b0;
      starve_cnt   <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_cs_n_q   <= 1'b1;
      ram_we_n_q   <= 1'b1;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      // The RAM cycle that just ended returns its read data to whichever port owned it.
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      if (rd_flag && (slot == CPU_ACC)) begin
        cpu_rvalid_q <= 1'b1;
        cpu_rdata_q  <= bus.ram_rdata;
      end
      if (rd_flag && (slot == DBG_ACC)) begin
        dbg_rvalid_q <= 1'b1;
        dbg_rdata_q  <= bus.ram_rdata;
      end

      if (cpu_xfer) begin
        slot        <= CPU_ACC;
        ram_addr_q  <= bus.cpu_addr;
        ram_wdata_q <= bus.cpu_wdata;
        ram_cs_n_q  <= 1'b0;
        ram_we_n_q  <= ~bus.cpu_we;
        rd_flag     <= ~bus.cpu_we;
      end else if (dbg_xfer) begin
        slot        <= DBG_ACC;
        ram_addr_q  <= bus.dbg_addr;
        ram_wdata_q <= bus.dbg_wdata;
        ram_cs_n_q  <= 1'b0;
        ram_we_n_q  <= ~bus.dbg_we;
        rd_flag     <= ~bus.dbg_we;
      end else begin
        slot       <= IDLE;
        ram_cs_n_q <= 1'b1;
        ram_we_n_q <= 1'b1;
        rd_flag    <= 1'b0;
      end

      if (dbg_xfer || !bus.dbg_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT_C) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.ram_cs_n   = ram_cs_n_q;
  assign bus.ram_we_n   = ram_we_n_q;
  assign slot_state     = slot;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance with a starvation limit of 4 and one
// with strict CPU priority, each attached to a behavioural single-port RAM.
module tb_ram_port_arbiter;

  logic       clk;
  logic       n_reset;
  logic [1:0] slot_a;
  logic [1:0] slot_b;
  int         checks;
  int         failures;
  int         gnt_cnt;
  int         dbg_hits;

  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:65535];

  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_a ();
  ram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_b ();

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STARVE_LIMIT(4)) dut_a (
    .clk        (clk),
    .n_reset    (n_reset),
    .bus        (bus_a.slave),
    .slot_state (slot_a)
  );

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .STARVE_LIMIT(0)) dut_b (
    .clk        (clk),
    .n_reset    (n_reset),
    .bus        (bus_b.slave),
    .slot_state (slot_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAMs execute on the negedge of the access cycle; reset restores the preload.
  always @(negedge clk) begin
    if (!n_reset) begin
      mem_a[16'h1234] <= 8'hA5;
      mem_a[16'h0000] <= 8'h11;
      mem_a[16'h0001] <= 8'h22;
      mem_a[16'h0002] <= 8'h33;
      mem_a[16'h0003] <= 8'h44;
    end else if (!bus_a.ram_cs_n) begin
      if (!bus_a.ram_we_n) mem_a[bus_a.ram_addr] <= bus_a.ram_wdata;
      else                 bus_a.ram_rdata <= mem_a[bus_a.ram_addr];
    end
  end

  always @(negedge clk) begin
    if (!n_reset) begin
      mem_b[16'h0042] <= 8'h77;
    end else if (!bus_b.ram_cs_n) begin
      if (!bus_b.ram_we_n) mem_b[bus_b.ram_addr] <= bus_b.ram_wdata;
      else                 bus_b.ram_rdata <= mem_b[bus_b.ram_addr];
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata);
    bus_a.cpu_req   = req;
    bus_a.cpu_we    = we;
    bus_a.cpu_addr  = addr;
    bus_a.cpu_wdata = wdata;
  endtask

  task automatic dbg_drive(input logic req, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata);
    bus_a.dbg_req   = req;
    bus_a.dbg_we    = we;
    bus_a.dbg_addr  = addr;
    bus_a.dbg_wdata = wdata;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus_a.ram_rdata = 8'h00;
    bus_b.ram_rdata = 8'h00;
    bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    bus_b.dbg_req = 1'b0; bus_b.dbg_we = 1'b0; bus_b.dbg_addr = '0; bus_b.dbg_wdata = '0;

    // 1: reset with both requests high
    n_reset = 1'b0;
    cpu_drive(1'b1, 1'b0, 16'h1234, 8'h00);
    dbg_drive(1'b1, 1'b0, 16'h0010, 8'h00);
    tick(); tick(); tick();
    check("rst_cs_n", bus_a.ram_cs_n, 1);
    check("rst_we_n", bus_a.ram_we_n, 1);
    check("rst_addr", bus_a.ram_addr, 0);
    check("rst_wdata", bus_a.ram_wdata, 0);
    check("rst_cpu_gnt", bus_a.cpu_gnt, 0);
    check("rst_dbg_gnt", bus_a.dbg_gnt, 0);
    check("rst_cpu_rvalid", bus_a.cpu_rvalid, 0);
    check("rst_dbg_rvalid", bus_a.dbg_rvalid, 0);
    check("rst_cpu_rdata", bus_a.cpu_rdata, 0);
    check("rst_dbg_rdata", bus_a.dbg_rdata, 0);
    check("rst_slot", slot_a, 0);

    cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    dbg_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    n_reset = 1'b1;
    tick(); tick();

    // 2: CPU read of preloaded 0x1234
    cpu_drive(1'b1, 1'b0, 16'h1234, 8'h00);
    settle();
    check("t2_cpu_gnt", bus_a.cpu_gnt, 1);
    check("t2_dbg_gnt", bus_a.dbg_gnt, 0);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    settle();
    check("t2_cs_n", bus_a.ram_cs_n, 0);
    check("t2_we_n", bus_a.ram_we_n, 1);
    check("t2_addr", bus_a.ram_addr, 16'h1234);
    check("t2_slot", slot_a, 1);
    check("t2_early_rvalid", bus_a.cpu_rvalid, 0);
    tick();
    settle();
    check("t2_rvalid", bus_a.cpu_rvalid, 1);
    check("t2_rdata", bus_a.cpu_rdata, 8'hA5);
    check("t2_dbg_rvalid", bus_a.dbg_rvalid, 0);
    check("t2_idle_cs_n", bus_a.ram_cs_n, 1);
    tick();
    settle();
    check("t2_rvalid_drop", bus_a.cpu_rvalid, 0);
    check("t2_rdata_hold", bus_a.cpu_rdata, 8'hA5);

    // 3: debug write then CPU read of the same address
    dbg_drive(1'b1, 1'b1, 16'h0010, 8'h5A);
    settle();
    check("t3_dbg_gnt", bus_a.dbg_gnt, 1);
    tick();
    dbg_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    cpu_drive(1'b1, 1'b0, 16'h0010, 8'h00);
    settle();
    check("t3_w_cs_n", bus_a.ram_cs_n, 0);
    check("t3_w_we_n", bus_a.ram_we_n, 0);
    check("t3_w_addr", bus_a.ram_addr, 16'h0010);
    check("t3_w_wdata", bus_a.ram_wdata, 8'h5A);
    check("t3_cpu_gnt", bus_a.cpu_gnt, 1);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    settle();
    check("t3_r_cs_n", bus_a.ram_cs_n, 0);
    check("t3_r_we_n", bus_a.ram_we_n, 1);
    check("t3_no_wr_rvalid", bus_a.dbg_rvalid, 0);
    tick();
    settle();
    check("t3_rvalid", bus_a.cpu_rvalid, 1);
    check("t3_rdata", bus_a.cpu_rdata, 8'h5A);
    tick(); tick();

    // 4: starvation limit 4, CPU requesting continuously
    cpu_drive(1'b1, 1'b0, 16'h0001, 8'h00);
    dbg_drive(1'b1, 1'b0, 16'h1234, 8'h00);
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("t4_cpu_gnt_T%0d", i), bus_a.cpu_gnt, 1);
      check($sformatf("t4_dbg_gnt_T%0d", i), bus_a.dbg_gnt, 0);
      tick();
    end
    settle();
    check("t4_dbg_gnt_T4", bus_a.dbg_gnt, 1);
    check("t4_cpu_gnt_T4", bus_a.cpu_gnt, 0);
    tick();
    dbg_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    settle();
    check("t4_cpu_gnt_T5", bus_a.cpu_gnt, 1);
    check("t4_dbg_gnt_T5", bus_a.dbg_gnt, 0);
    check("t4_slot_T5", slot_a, 2);
    check("t4_addr_T5", bus_a.ram_addr, 16'h1234);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    settle();
    check("t4_dbg_rvalid_T6", bus_a.dbg_rvalid, 1);
    check("t4_dbg_rdata_T6", bus_a.dbg_rdata, 8'hA5);
    check("t4_cpu_rvalid_T6", bus_a.cpu_rvalid, 0);
    tick();
    settle();
    check("t4_cpu_rvalid_T7", bus_a.cpu_rvalid, 1);
    check("t4_cpu_rdata_T7", bus_a.cpu_rdata, 8'h22);
    check("t4_dbg_rvalid_T7", bus_a.dbg_rvalid, 0);
    tick(); tick();

    // 6: back-to-back CPU reads, then reset during a fourth access
    cpu_drive(1'b1, 1'b0, 16'h0000, 8'h00);
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0001, 8'h00);
    settle();
    check("t6_rvalid_pre", bus_a.cpu_rvalid, 0);
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0002, 8'h00);
    settle();
    check("t6_rvalid0", bus_a.cpu_rvalid, 1);
    check("t6_rdata0", bus_a.cpu_rdata, 8'h11);
    tick();
    cpu_drive(1'b1, 1'b0, 16'h0003, 8'h00);
    settle();
    check("t6_rvalid1", bus_a.cpu_rvalid, 1);
    check("t6_rdata1", bus_a.cpu_rdata, 8'h22);
    tick();
    cpu_drive(1'b0, 1'b0, 16'h0000, 8'h00);
    settle();
    check("t6_rvalid2", bus_a.cpu_rvalid, 1);
    check("t6_rdata2", bus_a.cpu_rdata, 8'h33);
    check("t6_acc4_cs_n", bus_a.ram_cs_n, 0);
    #1;
    n_reset = 1'b0;
    #1;
    check("t6_abort_cs_n", bus_a.ram_cs_n, 1);
    check("t6_abort_rvalid", bus_a.cpu_rvalid, 0);
    tick();
    check("t6_no_rvalid4_a", bus_a.cpu_rvalid, 0);
    n_reset = 1'b1;
    tick();
    settle();
    check("t6_no_rvalid4_b", bus_a.cpu_rvalid, 0);
    check("t6_rdata_cleared", bus_a.cpu_rdata, 0);
    check("t6_idle_cs_n", bus_a.ram_cs_n, 1);

    // 5: strict CPU priority on the second instance
    bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 16'h0000;
    bus_b.dbg_req = 1'b1; bus_b.dbg_we = 1'b0; bus_b.dbg_addr = 16'h0042;
    gnt_cnt  = 0;
    dbg_hits = 0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (bus_b.dbg_gnt === 1'b1) dbg_hits++;
      if (bus_b.cpu_gnt === 1'b1) gnt_cnt++;
      tick();
    end
    check("t5_dbg_never", dbg_hits, 0);
    check("t5_cpu_all", gnt_cnt, 100);
    bus_b.cpu_req = 1'b0;
    settle();
    check("t5_dbg_gnt_free", bus_b.dbg_gnt, 1);
    tick();
    bus_b.dbg_req = 1'b0;
    settle();
    check("t5_dbg_slot", slot_b, 2);
    check("t5_dbg_addr", bus_b.ram_addr, 16'h0042);
    tick();
    settle();
    check("t5_dbg_rvalid", bus_b.dbg_rvalid, 1);
    check("t5_dbg_rdata", bus_b.dbg_rdata, 8'h77);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
